wb_serial_master: RTL and testbench

WB_SERIAL_MASTER -- requirements
Module: wb_serial_master

---
 rtl/wb_serial_master.sv | 174 +++++++++++++++++
 tb/tb_wb_serial_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_serial_master.sv
// wb_serial_master: turns a byte-stream command link into single Wishbone
// word transfers. Frame: cmd, 4 address bytes, optional 4 data bytes (MSB
// first). Each accepted command yields a status byte (0x06 ok / 0x15 fail),
// followed by 4 read-data bytes for a successful read.
module wb_serial_master #(
    parameter int unsigned timeout_cycles = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_WDATA  = 3'd2;
    localparam logic [2:0] S_BUS    = 3'd3;
    localparam logic [2:0] S_STATUS = 3'd4;
    localparam logic [2:0] S_RDATA  = 3'd5;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;
    localparam logic [7:0] ST_OK  = 8'h06;
    localparam logic [7:0] ST_BAD = 8'h15;

    // Counter value seen in the last permitted bus cycle; the counter starts
    // at 0 on the first cycle, so cyc stays high exactly timeout_cycles cycles.
    localparam logic [15:0] TMO_LAST = 16'(timeout_cycles - 1);

    logic [2:0]  r_state;
    logic [1:0]  r_cnt;
    logic [15:0] r_tmo;
    logic [31:0] r_adr;
    logic [31:0] r_wdat;
    logic [31:0] r_rdata;
    logic [7:0]  r_status;
    logic        r_we;
    logic        r_cyc;

    logic w_rx_fire;
    logic w_tx_fire;
    logic w_bus_ok;
    logic w_bus_end;

    // Bytes are only taken while a command is being assembled; reset forces 0.
    assign rx_ready  = ~reset & ((r_state == S_IDLE) | (r_state == S_ADDR) |
                                 (r_state == S_WDATA));
    assign w_rx_fire = rx_valid & rx_ready;
    assign tx_valid  = (r_state == S_STATUS) | (r_state == S_RDATA);
    assign w_tx_fire = tx_valid & tx_ready;

    // Ack together with err counts as an error.
    assign w_bus_ok  = wb_ack_i & ~wb_err_i;
    assign w_bus_end = wb_ack_i | wb_err_i;

    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_wdat;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign wb_we_o  = r_cyc & r_we;
    assign wb_sel_o = r_cyc ? 4'hF : 4'h0;

    // Response byte mux: status first, then read data MSB first.
    always_comb begin
        tx_data = 8'h00;
        if (r_state == S_STATUS)
            tx_data = r_status;
        else if (r_state == S_RDATA)
            tx_data = r_rdata[31:24];
    end

    // Command assembly, bus cycle with timeout, and response sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 2'd0;
            r_tmo    <= 16'd0;
            r_adr    <= 32'd0;
            r_wdat   <= 32'd0;
            r_rdata  <= 32'd0;
            r_status <= 8'h00;
            r_we     <= 1'b0;
            r_cyc    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Unknown command bytes are swallowed silently.
                    if (w_rx_fire && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
                        r_state <= S_ADDR;
                        r_we    <= (rx_data == CMD_WR);
                        r_cnt   <= 2'd0;
                    end
                end
                S_ADDR: begin
                    if (w_rx_fire) begin
                        r_adr <= {r_adr[23:0], rx_data};
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            if (r_we) begin
                                r_state <= S_WDATA;
                            end else begin
                                r_state <= S_BUS;
                                r_cyc   <= 1'b1;
                                r_tmo   <= 16'd0;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (w_rx_fire) begin
                        r_wdat <= {r_wdat[23:0], rx_data};
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= S_BUS;
                            r_cyc   <= 1'b1;
                            r_tmo   <= 16'd0;
                        end
                    end
                end
                S_BUS: begin
                    // A response in the final cycle beats the timeout.
                    if (w_bus_end) begin
                        r_cyc    <= 1'b0;
                        r_state  <= S_STATUS;
                        r_status <= w_bus_ok ? ST_OK : ST_BAD;
                        if (w_bus_ok && !r_we)
                            r_rdata <= wb_dat_i;
                    end else if (r_tmo == TMO_LAST) begin
                        r_cyc    <= 1'b0;
                        r_state  <= S_STATUS;
                        r_status <= ST_BAD;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                S_STATUS: begin
                    if (w_tx_fire) begin
                        r_cnt <= 2'd0;
                        if (!r_we && r_status == ST_OK)
                            r_state <= S_RDATA;
                        else
                            r_state <= S_IDLE;
                    end
                end
                S_RDATA: begin
                    if (w_tx_fire) begin
                        r_rdata <= {r_rdata[23:0], 8'h00};
                        r_cnt   <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3)
                            r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_serial_master.sv
// Directed bench for wb_serial_master: a table of complete transactions plus
// hand-written reset-abort sequences. Inputs change and outputs are sampled
// on the falling edge.
module tb_wb_serial_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = 32'd0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    always #5 clk = ~clk;

    wb_serial_master #(.timeout_cycles(8)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    // mode: 0 ack, 1 ack+err, 2 no response, 3 err only
    typedef struct {
        logic [7:0]  garbage;
        logic [7:0]  cmd;
        logic [31:0] adr;
        logic [31:0] wdat;
        int          mode;
        int          dly;
        logic [31:0] rdat;
        bit          bp;
        int          exp_n;
        logic [7:0]  exp_st;
        int          exp_cyc;
    } vec_t;

    vec_t vec[8];

    int checks = 0;
    int failures = 0;
    int cur_idx = -1;

    logic [7:0]  tx_q[$];
    int          cur_mode = 2;
    int          cur_dly = 0;
    logic [31:0] cur_rdat = 32'd0;
    bit          bp = 1'b0;
    bit          mon_en = 1'b0;
    int          cyc_cnt = 0;
    int          cyc_total = 0;
    logic [31:0] mon_adr = 32'd0, mon_dat = 32'd0;
    logic        mon_we = 1'b0;
    logic [3:0]  mon_sel = 4'h0;
    bit          stall_p = 1'b0;
    logic [7:0]  stall_d = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (vec %0d): actual=%h expected=%h", name, cur_idx, act, exp);
        end
    endtask

    // Wishbone slave model and bus-protocol monitor.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            chk("cyc_eq_stb", 32'(wb_cyc_o), 32'(wb_stb_o));
            if (wb_cyc_o) begin
                cyc_cnt++;
                cyc_total++;
                if (cyc_cnt == 1) begin
                    mon_adr = wb_adr_o;
                    mon_dat = wb_dat_o;
                    mon_we  = wb_we_o;
                    mon_sel = wb_sel_o;
                end else begin
                    chk("adr_stable", wb_adr_o, mon_adr);
                    chk("dat_stable", wb_dat_o, mon_dat);
                end
                chk("sel_in_cyc", 32'(wb_sel_o), 32'hF);
                chk("rx_ready_in_bus", 32'(rx_ready), 32'd0);
                wb_ack_i = (cyc_cnt == cur_dly + 1) && (cur_mode == 0 || cur_mode == 1);
                wb_err_i = (cyc_cnt == cur_dly + 1) && (cur_mode == 1 || cur_mode == 3);
                wb_dat_i = wb_ack_i ? cur_rdat : 32'hCAFEF00D;
            end else begin
                cyc_cnt  = 0;
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                wb_dat_i = 32'hCAFEF00D;
                if (wb_we_o) chk("we_outside_cyc", 32'(wb_we_o), 32'd0);
            end
        end
    end

    // Response sink: optional random backpressure, stall-stability check.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (stall_p) begin
                chk("stall_valid", 32'(tx_valid), 32'd1);
                chk("stall_data", 32'(tx_data), 32'(stall_d));
            end
            if (tx_valid) chk("rx_ready_in_resp", 32'(rx_ready), 32'd0);
            tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            stall_p  = tx_valid && !tx_ready;
            stall_d  = tx_data;
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        end
    end

    // Offer one byte and hold it until accepted (called at a falling edge).
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rx_accept_in_time", 32'(n < 50), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] adr,
                            input logic [31:0] wdat);
        send_byte(cmd);
        for (int b = 0; b < 4; b++) send_byte(adr[31-8*b -: 8]);
        if (cmd == 8'h01)
            for (int b = 0; b < 4; b++) send_byte(wdat[31-8*b -: 8]);
    endtask

    task automatic do_txn(input vec_t v);
        int n = 0;
        tx_q.delete();
        cyc_total = 0;
        cur_mode  = v.mode;
        cur_dly   = v.dly;
        cur_rdat  = v.rdat;
        bp        = v.bp;
        if (v.garbage != 8'h00) begin
            send_byte(v.garbage);
            repeat (3) @(negedge clk);
            chk("garbage_stays_idle", 32'(rx_ready), 32'd1);
            chk("garbage_no_cyc", 32'(cyc_total), 32'd0);
            chk("garbage_no_tx", 32'(tx_q.size()), 32'd0);
        end
        send_cmd(v.cmd, v.adr, v.wdat);
        while (tx_q.size() < v.exp_n && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("resp_in_time", 32'(n < 300), 32'd1);
        repeat (12) @(negedge clk);
        chk("tx_count", 32'(tx_q.size()), 32'(v.exp_n));
        if (tx_q.size() > 0) chk("status", 32'(tx_q[0]), 32'(v.exp_st));
        for (int k = 1; k < v.exp_n && k < tx_q.size(); k++)
            chk("rd_byte", 32'(tx_q[k]), 32'(v.rdat[31-8*(k-1) -: 8]));
        chk("cyc_cycles", 32'(cyc_total), 32'(v.exp_cyc));
        chk("bus_adr", mon_adr, v.adr);
        chk("bus_we", 32'(mon_we), 32'(v.cmd == 8'h01));
        chk("bus_sel", 32'(mon_sel), 32'hF);
        if (v.cmd == 8'h01) chk("bus_dat", mon_dat, v.wdat);
        chk("back_idle_rx", 32'(rx_ready), 32'd1);
        chk("back_idle_tx", 32'(tx_valid), 32'd0);
        bp = 1'b0;
    endtask

    initial begin
        //             garb   cmd    adr           wdat          mode dly rdat        bp  n  st     cyc
        vec[0] = '{8'h00, 8'h01, 32'h0000_7000, 32'hDEAD_BEEF, 0, 2, 32'h0,         0, 1, 8'h06, 3};
        vec[1] = '{8'h7F, 8'h02, 32'h0000_0010, 32'h0,         0, 0, 32'h1234_5678, 0, 5, 8'h06, 1};
        vec[2] = '{8'h00, 8'h02, 32'h0000_0020, 32'h0,         2, 0, 32'h0,         0, 1, 8'h15, 8};
        vec[3] = '{8'h00, 8'h01, 32'h0000_0100, 32'h0000_55AA, 1, 1, 32'h0,         0, 1, 8'h15, 2};
        vec[4] = '{8'h00, 8'h02, 32'h0000_0013, 32'h0,         0, 3, 32'hA5C3_0F81, 1, 5, 8'h06, 4};
        vec[5] = '{8'h00, 8'h02, 32'h0000_0024, 32'h0,         0, 7, 32'h0BAD_C0DE, 0, 5, 8'h06, 8};
        vec[6] = '{8'h00, 8'h02, 32'h0000_0028, 32'h0,         3, 0, 32'h1111_1111, 0, 1, 8'h15, 1};
        vec[7] = '{8'h00, 8'h01, 32'hFFFF_FFFC, 32'h0102_0304, 3, 7, 32'h0,         0, 1, 8'h15, 8};

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_sel", 32'(wb_sel_o), 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rx_ready_after_rst", 32'(rx_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            cur_idx = i;
            do_txn(vec[i]);
        end

        // Reset while write data is arriving: no bus cycle, no response.
        cur_idx   = 100;
        tx_q.delete();
        cyc_total = 0;
        cur_mode  = 0;
        cur_dly   = 0;
        send_byte(8'h01);
        for (int b = 0; b < 4; b++) send_byte(8'h10 + 8'(b));
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        @(negedge clk);
        chk("wdata_rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("wdata_rst_cyc", 32'(wb_cyc_o), 32'd0);
        reset = 1'b0;
        send_byte(8'hCC);
        send_byte(8'hDD);
        repeat (15) @(negedge clk);
        chk("wdata_rst_no_cyc", 32'(cyc_total), 32'd0);
        chk("wdata_rst_no_tx", 32'(tx_q.size()), 32'd0);
        chk("wdata_rst_idle", 32'(rx_ready), 32'd1);

        // Reset during a bus cycle: cyc drops on that edge, no status byte.
        cur_idx   = 101;
        tx_q.delete();
        cyc_total = 0;
        cur_mode  = 2;
        send_cmd(8'h02, 32'h0000_0040, 32'h0);
        begin
            int n = 0;
            while (!wb_cyc_o && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("bus_rst_cyc_seen", 32'(wb_cyc_o), 32'd1);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("bus_rst_cyc_drop", 32'(wb_cyc_o), 32'd0);
        chk("bus_rst_stb_drop", 32'(wb_stb_o), 32'd0);
        chk("bus_rst_tx_valid", 32'(tx_valid), 32'd0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("bus_rst_cyc_cycles", 32'(cyc_total), 32'd3);
        chk("bus_rst_no_tx", 32'(tx_q.size()), 32'd0);

        // Normal traffic resumes after the aborted commands.
        cur_idx = 102;
        do_txn(vec[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule
